sub_bytes_seq: RTL and testbench

SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

---
 rtl/sub_bytes_seq.sv | 136 +++++++++++++
 tb/tb_sub_bytes_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: a 128-bit state is substituted one 32-bit column per cycle.
// Define SUB_BYTES_FAST_EN to build 16 S-box lanes that substitute the whole state in the capture cycle.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    // Forward AES S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX[a_i];
endmodule

module sub_bytes_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] buf_q, buf_d;

`ifdef SUB_BYTES_FAST_EN
    logic [127:0] sub_all;

    for (genvar i = 0; i < 16; i++) begin : g_lane
        aes_sbox u_sbox (
            .a_i (in_state[127-8*i -: 8]),
            .s_o (sub_all[127-8*i -: 8])
        );
    end
`else
    logic [31:0] col_in;
    logic [31:0] col_sub;

    always_comb begin
        col_in = buf_q[127:96];
        case (cnt_q)
            2'd0: col_in = buf_q[127:96];
            2'd1: col_in = buf_q[95:64];
            2'd2: col_in = buf_q[63:32];
            2'd3: col_in = buf_q[31:0];
            default: col_in = buf_q[127:96];
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        aes_sbox u_sbox (
            .a_i (col_in[31-8*i -: 8]),
            .s_o (col_sub[31-8*i -: 8])
        );
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = 2'd0;
`ifdef SUB_BYTES_FAST_EN
                    buf_d   = sub_all;
                    state_d = DONE;
`else
                    buf_d   = in_state;
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
`ifndef SUB_BYTES_FAST_EN
                // Write the substituted column back in place.
                case (cnt_q)
                    2'd0: buf_d[127:96] = col_sub;
                    2'd1: buf_d[95:64]  = col_sub;
                    2'd2: buf_d[63:32]  = col_sub;
                    2'd3: buf_d[31:0]   = col_sub;
                    default: buf_d = buf_q;
                endcase
`endif
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_state = buf_q;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: directed vector table, hold/ignore/abort sequences and a back-to-back run.
// Honours SUB_BYTES_FAST_EN to pick the expected latency.

module tb_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int checks = 0;
    int errors = 0;

`ifdef SUB_BYTES_FAST_EN
    localparam int LAT     = 0;
    localparam int SPACING = 2;
`else
    localparam int LAT     = 4;
    localparam int SPACING = 6;
`endif

    sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] a);
        logic [7:0] inv = 8'h0;
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes_model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox_model(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Accept one block, then wait (bounded) for out_valid; leaves the DUT in DONE.
    task automatic send_and_wait(input string tag, input logic [127:0] din,
                                 input logic [127:0] exp, input int exp_lat);
        int n;
        chk({tag, " in_ready before accept"}, 128'(in_ready), 128'(1'b1));
        in_state = din;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(exp_lat));
        chk({tag, " data"}, out_state, exp);
        chk({tag, " in_ready in DONE"}, 128'(in_ready), 128'(1'b0));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        chk({tag, " out_valid after release"}, 128'(out_valid), 128'(1'b0));
        chk({tag, " in_ready after release"}, 128'(in_ready), 128'(1'b1));
    endtask

    logic [127:0] blk [8];
    logic [127:0] bexp [8];

    initial begin
        logic [127:0] a_dat, b_dat;
        int cyc, k, j, last_acc;
        logic acc, ov;
        logic [127:0] os;

        vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
        vecs[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h16161616161616161616161616161616};
        vecs[3] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = 128'h0;
        step();
        step();
        rst = 1'b0;
        chk("reset out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset out_state", out_state, 128'h0);

        // Table vectors; out_ready held high also while the block is in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_and_wait($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout, LAT);
            release_out($sformatf("vec%0d", i));
        end

        // Hold in DONE for 10 cycles, with a stray in_valid that must be ignored.
        out_ready = 1'b0;
        send_and_wait("hold", vecs[3].din, vecs[3].dout, LAT);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            in_state = vecs[1].din;
            step();
            in_valid = 1'b0;
            chk($sformatf("hold out_valid c%0d", c), 128'(out_valid), 128'(1'b1));
            chk($sformatf("hold out_state c%0d", c), out_state, vecs[3].dout);
            chk($sformatf("hold in_ready c%0d", c), 128'(in_ready), 128'(1'b0));
        end
        release_out("hold");

        // Second in_valid right after accept, with different data, must be ignored.
        a_dat = 128'h0123456789abcdeffedcba9876543210;
        b_dat = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
        out_ready = 1'b0;
        in_state = a_dat;
        in_valid = 1'b1;
        step();
        in_state = b_dat;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && out_valid !== 1'b1; n++) step();
        chk("ignore out_valid", 128'(out_valid), 128'(1'b1));
        chk("ignore data", out_state, sub_bytes_model(a_dat));
        release_out("ignore");

        // Abort mid-block with reset; the partial result must never appear.
        out_ready = 1'b0;
        in_state = vecs[0].din;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("abort out_valid", 128'(out_valid), 128'(1'b0));
        chk("abort in_ready", 128'(in_ready), 128'(1'b1));
        chk("abort out_state", out_state, 128'h0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("abort quiet c%0d", c), 128'(out_valid), 128'(1'b0));
        end
        send_and_wait("after abort", vecs[0].din, vecs[0].dout, LAT);
        release_out("after abort");

        // Back-to-back blocks with in_valid held high.
        for (int i = 0; i < 8; i++) begin
            blk[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            bexp[i] = sub_bytes_model(blk[i]);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = blk[0];
        cyc = 0; k = 0; j = 0; last_acc = 0;
        while (j < 8 && cyc < 200) begin
            acc = in_ready && in_valid;
            ov  = out_valid;
            os  = out_state;
            step();
            cyc++;
            if (ov) begin
                chk($sformatf("b2b data %0d", j), os, bexp[j]);
                j++;
            end
            if (acc) begin
                if (k > 0) chk($sformatf("b2b spacing %0d", k), 128'(cyc - last_acc), 128'(SPACING));
                last_acc = cyc;
                k++;
                if (k < 8) in_state = blk[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b results received", 128'(j), 128'(8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
